param_reorder_buffer: RTL

//  Parametrised in-order-commit reorder buffer (ROB) sitting between Decoder, the
//  RS/LSB writeback channels, RegFile and MemController. Allocates one entry per cycle
//  at tail, accepts out-of-order results on two writeback channels, and commits one

---
 rtl/param_reorder_buffer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/param_reorder_buffer.sv
// In-order-commit reorder buffer: allocates at tail, takes out-of-order results on
// two writeback channels, commits one entry per cycle at head, flushes on mispredict.
// Optional feature macro: ROB_PERF_CNT_EN adds perf_commits / perf_flushes counters.
module param_reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_id,
    input  logic [1:0]        alloc_kind,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic [DATA_W-1:0] alloc_pred_pc,
    input  logic              wb0_valid,
    input  logic [IDX_W-1:0]  wb0_id,
    input  logic [DATA_W-1:0] wb0_value,
    input  logic [DATA_W-1:0] wb0_target,
    input  logic              wb1_valid,
    input  logic [IDX_W-1:0]  wb1_id,
    input  logic [DATA_W-1:0] wb1_value,
    input  logic [DATA_W-1:0] wb1_addr,
    output logic              rf_valid,
    output logic [IDX_W-1:0]  rf_id,
    output logic [REG_W-1:0]  rf_rd,
    output logic [DATA_W-1:0] rf_value,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [DATA_W-1:0] st_addr,
    output logic [DATA_W-1:0] st_value,
    output logic              flush,
    output logic [DATA_W-1:0] flush_pc,
    output logic [IDX_W:0]    count
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_commits,
    output logic [31:0]       perf_flushes
`endif
);

    localparam logic [1:0] K_REG    = 2'd0;
    localparam logic [1:0] K_STORE  = 2'd1;
    localparam logic [1:0] K_BRANCH = 2'd2;
    localparam logic [1:0] K_JUMP   = 2'd3;

    localparam logic [IDX_W:0]   FULL   = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   CNT_1  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] ID_1   = IDX_W'(1);

    // per-entry state; tgt holds resolved next PC (wb0) or store address (wb1)
    logic [DEPTH-1:0]  busy, done;
    logic [1:0]        kind_q [DEPTH];
    logic [REG_W-1:0]  rd_q   [DEPTH];
    logic [DATA_W-1:0] pred_q [DEPTH];
    logic [DATA_W-1:0] val_q  [DEPTH];
    logic [DATA_W-1:0] tgt_q  [DEPTH];
    logic [IDX_W-1:0]  head, tail;

    logic       head_ok, h_ctl, h_wr, mispredict, st_start, pop, do_alloc;
    logic [1:0] h_kind;

    assign alloc_ready = (count != FULL) && !flush;
    assign alloc_id    = tail;
    assign h_kind      = kind_q[head];
    assign head_ok     = busy[head] && done[head];
    assign h_ctl       = (h_kind == K_BRANCH) || (h_kind == K_JUMP);
    assign h_wr        = (h_kind == K_REG) || (h_kind == K_JUMP);
    assign mispredict  = rdy && head_ok && h_ctl && (tgt_q[head] != pred_q[head]);
    // a store is presented first, then popped once the memory side accepts it
    assign st_start    = rdy && head_ok && (h_kind == K_STORE) && !st_valid;
    assign pop         = rdy && head_ok && ((h_kind == K_STORE) ? (st_valid && st_ready) : 1'b1);
    assign do_alloc    = rdy && alloc_valid && alloc_ready;

    // entry payload: writebacks (wb0 ordered last so it wins) and alloc fields
    always_ff @(posedge clk) begin
        if (!rst && rdy && !mispredict) begin
            if (wb1_valid && busy[wb1_id]) begin
                val_q[wb1_id] <= wb1_value;
                tgt_q[wb1_id] <= wb1_addr;
            end
            if (wb0_valid && busy[wb0_id]) begin
                val_q[wb0_id] <= wb0_value;
                tgt_q[wb0_id] <= wb0_target;
            end
            if (do_alloc) begin
                kind_q[tail] <= alloc_kind;
                rd_q[tail]   <= alloc_rd;
                pred_q[tail] <= alloc_pred_pc;
            end
        end
    end

    // pointers, status bits, commit outputs and flush
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            done     <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            rf_valid <= 1'b0;
            rf_id    <= '0;
            rf_rd    <= '0;
            rf_value <= '0;
            st_valid <= 1'b0;
            st_addr  <= '0;
            st_value <= '0;
            flush    <= 1'b0;
            flush_pc <= '0;
        end else if (!rdy) begin
            rf_valid <= 1'b0;
            flush    <= 1'b0;
        end else begin
            rf_valid <= 1'b0;
            flush    <= 1'b0;
            if (pop && h_wr) begin
                rf_valid <= 1'b1;
                rf_id    <= head;
                rf_rd    <= rd_q[head];
                rf_value <= val_q[head];
            end
            if (st_start) begin
                st_valid <= 1'b1;
                st_addr  <= tgt_q[head];
                st_value <= val_q[head];
            end else if (pop && (h_kind == K_STORE)) begin
                st_valid <= 1'b0;
            end
            if (mispredict) begin
                busy     <= '0;
                done     <= '0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                flush    <= 1'b1;
                flush_pc <= tgt_q[head];
            end else begin
                if (wb1_valid && busy[wb1_id]) done[wb1_id] <= 1'b1;
                if (wb0_valid && busy[wb0_id]) done[wb0_id] <= 1'b1;
                if (pop) begin
                    busy[head] <= 1'b0;
                    done[head] <= 1'b0;
                    head       <= head + ID_1;
                end
                if (do_alloc) begin
                    busy[tail] <= 1'b1;
                    done[tail] <= 1'b0;
                    tail       <= tail + ID_1;
                end
                if (do_alloc && !pop)      count <= count + CNT_1;
                else if (!do_alloc && pop) count <= count - CNT_1;
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    // free-running event counters, frozen while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commits <= '0;
            perf_flushes <= '0;
        end else if (rdy) begin
            if (pop)        perf_commits <= perf_commits + 32'd1;
            if (mispredict) perf_flushes <= perf_flushes + 32'd1;
        end
    end
`else
    // no performance counters in this build
`endif

endmodule
